edit_sequencer: RTL and testbench

Front-panel edit controller for the HH:MM:SS clock. It turns three debounced, active-low keys into a mode state machine (run, arm, edit seconds/minutes/hours) and into single-cycle inc/dec strobes with auto-repeat. It also produces the run-enable, field-select and per-field blink mask that drive the time counters and the seven-segment display. It sits between the key inputs and the time/display datapath, and pauses timekeeping while a field is being edited.

---
 rtl/edit_sequencer.sv | 179 +++++++++++++++++
 tb/tb_edit_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/edit_sequencer.sv
// rtl/edit_sequencer.sv - front-panel mode FSM, inc/dec auto-repeat strobes and blink mask for the HH:MM:SS clock
module edit_sequencer #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int HOLD_MS         = 1000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int BLINK_MS        = 1000,
    parameter int IDLE_S          = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_mode_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic       run_en,
    output logic [2:0] field_sel,
    output logic       inc,
    output logic       dec,
    output logic [2:0] blank,
    output logic       editing
);
    localparam int DIV     = CLK_HZ / 1000;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDLE_MS = IDLE_S * 1000;
    localparam int IDLE_W  = $clog2(IDLE_MS + 1);
    localparam int REP_W   = $clog2(REPEAT_DELAY_MS + 1);
    localparam int PH_W    = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int DARK_MS = 200;

    typedef enum logic [2:0] {ST_RUN, ST_ARM, ST_EDIT_S, ST_EDIT_M, ST_EDIT_H} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic                mode_p, up_p, dn_p;
    logic                mode_q, up_q, dn_q;
    logic                mode_edge, up_edge, dn_edge, any_edge;
    logic [11:0]         hold_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [REP_W-1:0]    rep_cnt;
    logic                rep_armed;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic                hold_done, idle_done;
    logic                one_held, both_held, fresh, rep_fire;
    logic                up_go, dn_go, strobe_ok, edit_cur, edit_nxt;
    logic                run_en_d, inc_d, dec_d, editing_d;
    logic [2:0]          field_sel_d, blank_d;

    function automatic logic is_edit(state_t s);
        return (s == ST_EDIT_S) || (s == ST_EDIT_M) || (s == ST_EDIT_H);
    endfunction

    assign mode_p    = ~key_mode_n;
    assign up_p      = ~key_up_n;
    assign dn_p      = ~key_dn_n;
    assign mode_edge = mode_p & ~mode_q;
    assign up_edge   = up_p & ~up_q;
    assign dn_edge   = dn_p & ~dn_q;
    assign any_edge  = mode_edge | up_edge | dn_edge;
    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign hold_done = tick && (hold_cnt == 12'(HOLD_MS - 1));
    assign idle_done = tick && (idle_cnt == IDLE_W'(IDLE_MS - 1));
    assign edit_cur  = is_edit(state);
    assign edit_nxt  = is_edit(state_nxt);

    // A key left alone after the other one is released restarts its delay like a new press
    assign one_held  = up_p ^ dn_p;
    assign both_held = up_p & dn_p;
    assign fresh     = one_held & up_q & dn_q;
    assign rep_fire  = one_held && rep_armed && !up_edge && !dn_edge && !fresh && tick
                       && (rep_cnt == REP_W'(REPEAT_DELAY_MS - 1));
    assign up_go     = (up_edge & ~dn_p) | (rep_fire & up_p);
    assign dn_go     = (dn_edge & ~up_p) | (rep_fire & dn_p);
    // Strobes are dropped whenever the state moves, so a mode edge wins over up/down
    assign strobe_ok = edit_cur && !mode_edge && (state_nxt == state);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (mode_p) state_nxt = ST_ARM;
            ST_ARM:    if (!mode_p) state_nxt = ST_RUN;
                       else if (hold_done) state_nxt = ST_EDIT_S;
            ST_EDIT_S: if (mode_edge) state_nxt = ST_EDIT_M;
                       else if (idle_done) state_nxt = ST_RUN;
            ST_EDIT_M: if (mode_edge) state_nxt = ST_EDIT_H;
                       else if (idle_done) state_nxt = ST_RUN;
            ST_EDIT_H: if (mode_edge || idle_done) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Blink phase restarts at every state change so each newly selected field starts dark
    always_comb begin
        phase_nxt = phase;
        if (state_nxt != state)           phase_nxt = '0;
        else if (tick)                    phase_nxt = (phase == PH_W'(BLINK_MS - 1)) ? '0 : phase + 1'b1;
    end

    // Output decode from the next state, registered below
    always_comb begin
        run_en_d    = ~edit_nxt;
        editing_d   = edit_nxt;
        field_sel_d = 3'b000;
        case (state_nxt)
            ST_EDIT_S: field_sel_d = 3'b001;
            ST_EDIT_M: field_sel_d = 3'b010;
            ST_EDIT_H: field_sel_d = 3'b100;
            default:   field_sel_d = 3'b000;
        endcase
        blank_d = ~(field_sel_d & {3{phase_nxt < PH_W'(DARK_MS)}});
        inc_d   = strobe_ok & up_go;
        dec_d   = strobe_ok & dn_go;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_en    <= 1'b1;
            field_sel <= 3'b000;
            inc       <= 1'b0;
            dec       <= 1'b0;
            blank     <= 3'b111;
            editing   <= 1'b0;
        end else begin
            run_en    <= run_en_d;
            field_sel <= field_sel_d;
            inc       <= inc_d;
            dec       <= dec_d;
            blank     <= blank_d;
            editing   <= editing_d;
        end
    end

    // Tick divider, hold/idle/repeat timers and key history; keys held through reset are not edges
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            phase     <= '0;
            mode_q    <= mode_p;
            up_q      <= up_p;
            dn_q      <= dn_p;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            mode_q  <= mode_p;
            up_q    <= up_p;
            dn_q    <= dn_p;
            phase   <= phase_nxt;

            if (state != ST_ARM)            hold_cnt <= '0;
            else if (tick && hold_cnt != 12'hfff) hold_cnt <= hold_cnt + 1'b1;

            if (!edit_cur || any_edge)      idle_cnt <= '0;
            else if (tick && !idle_done)    idle_cnt <= idle_cnt + 1'b1;

            if (!up_p && !dn_p) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (both_held || up_edge || dn_edge || fresh) begin
                rep_cnt <= '0;
                if (up_edge || dn_edge) rep_armed <= 1'b1;
            end else if (rep_fire) begin
                rep_cnt <= REP_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
            end else if (rep_armed && tick) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_edit_sequencer.sv
// tb/tb_edit_sequencer.sv - directed vector bench for edit_sequencer at 1 ms per clock
module tb_edit_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_mode_n, key_up_n, key_dn_n;
    logic       run_en, inc, dec, editing;
    logic [2:0] field_sel, blank;

    always #5 clk = ~clk;

    edit_sequencer #(.CLK_HZ(1000)) dut (
        .clk(clk), .reset_n(reset_n),
        .key_mode_n(key_mode_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
        .run_en(run_en), .field_sel(field_sel), .inc(inc), .dec(dec),
        .blank(blank), .editing(editing)
    );

    // packed as {run_en, field_sel, inc, dec, blank, editing}
    localparam logic [9:0] V_RUN = {1'b1, 3'b000, 1'b0, 1'b0, 3'b111, 1'b0};
    localparam logic [9:0] V_ES0 = {1'b0, 3'b001, 1'b0, 1'b0, 3'b110, 1'b1};
    localparam logic [9:0] V_EM0 = {1'b0, 3'b010, 1'b0, 1'b0, 3'b101, 1'b1};
    localparam logic [9:0] V_EH0 = {1'b0, 3'b100, 1'b0, 1'b0, 3'b011, 1'b1};

    typedef struct {
        logic       m, u, d;
        int         cycles;
        logic       all;
        logic [9:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {run_en, field_sel, inc, dec, blank, editing};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic keys(input logic m, input logic u, input logic d);
        key_mode_n = ~m;
        key_up_n   = ~u;
        key_dn_n   = ~d;
    endtask

    task automatic enter_edit();
        keys(1, 0, 0);
        repeat (1001) step();
        keys(0, 0, 0);
        step();
        check("enter_edit", V_ES0);
    endtask

    task automatic mode_tap();
        keys(1, 0, 0);
        step();
        keys(0, 0, 0);
        step();
    endtask

    initial begin
        int incs[$];
        int decs[$];
        int both_hi;
        int strobes;
        int exp_a[6];
        logic [9:0] e;

        exp_a = '{0, 500, 600, 700, 800, 900};

        tbl[0]  = '{0, 0, 0, 5,    1'b1, V_RUN};
        tbl[1]  = '{0, 1, 0, 3,    1'b1, V_RUN};
        tbl[2]  = '{1, 0, 0, 999,  1'b1, V_RUN};
        tbl[3]  = '{0, 0, 0, 1,    1'b1, V_RUN};
        tbl[4]  = '{1, 0, 0, 1001, 1'b0, V_ES0};
        tbl[5]  = '{0, 0, 0, 1,    1'b0, V_ES0};
        tbl[6]  = '{1, 0, 0, 1,    1'b0, V_EM0};
        tbl[7]  = '{0, 0, 0, 1,    1'b0, V_EM0};
        tbl[8]  = '{1, 0, 0, 1,    1'b0, V_EH0};
        tbl[9]  = '{0, 0, 0, 1,    1'b0, V_EH0};
        tbl[10] = '{1, 0, 0, 1,    1'b0, V_RUN};
        tbl[11] = '{0, 0, 0, 2,    1'b1, V_RUN};
        tbl[12] = '{0, 1, 0, 1,    1'b0, V_RUN};
        tbl[13] = '{0, 0, 0, 1,    1'b0, V_RUN};

        reset_n = 1'b0;
        keys(0, 0, 0);
        step();
        step();
        check("reset", V_RUN);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            keys(tbl[i].m, tbl[i].u, tbl[i].d);
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step();
                if (tbl[i].all || c == tbl[i].cycles - 1)
                    check($sformatf("vec%0d_c%0d", i, c), tbl[i].exp);
            end
        end

        // auto-repeat of up in EDIT_M
        enter_edit();
        mode_tap();
        check("to_edit_m", V_EM0);
        keys(0, 1, 0);
        incs = {};
        decs = {};
        for (int c = 0; c < 1000; c++) begin
            step();
            if (inc) incs.push_back(c);
            if (dec) decs.push_back(c);
        end
        keys(0, 0, 0);
        step();
        check_int("repA_inc_count", incs.size(), 6);
        check_int("repA_dec_count", decs.size(), 0);
        for (int i = 0; i < 6; i++)
            if (i < incs.size()) check_int($sformatf("repA_inc%0d", i), incs[i], exp_a[i]);

        // both keys held, then up released: down restarts its delay
        mode_tap();
        mode_tap();
        check("back_to_run", V_RUN);
        enter_edit();
        incs = {};
        decs = {};
        both_hi = 0;
        for (int c = 0; c < 850; c++) begin
            keys(0, c < 300, c >= 200);
            step();
            if (inc) incs.push_back(c);
            if (dec) decs.push_back(c);
            if (inc && dec) both_hi++;
        end
        keys(0, 0, 0);
        step();
        check_int("repB_inc_count", incs.size(), 1);
        check_int("repB_dec_count", decs.size(), 1);
        if (incs.size() > 0) check_int("repB_inc_at", incs[0], 0);
        if (decs.size() > 0) check_int("repB_dec_at", decs[0], 800);
        check_int("repB_inc_dec_overlap", both_hi, 0);

        // mode edge and up edge in the same cycle: advance, no inc
        keys(1, 1, 0);
        step();
        check("mode_up_same_cycle", V_EM0);
        keys(0, 0, 0);
        step();
        check("after_mode_up", V_EM0);

        // EDIT_H blink pattern and idle timeout
        keys(1, 0, 0);
        step();
        check("idle_n0", V_EH0);
        keys(0, 0, 0);
        for (int n = 1; n <= 10000; n++) begin
            step();
            if (n < 10000) e = {1'b0, 3'b100, 1'b0, 1'b0, ((n % 1000) >= 200), 2'b11, 1'b1};
            else           e = V_RUN;
            check($sformatf("idle_n%0d", n), e);
        end

        // reset mid-edit with up held: no strobe until a new press
        enter_edit();
        mode_tap();
        keys(0, 1, 0);
        repeat (550) step();
        reset_n = 1'b0;
        step();
        check("reset_mid_edit", V_RUN);
        reset_n = 1'b1;
        strobes = 0;
        keys(1, 1, 0);
        for (int c = 0; c < 1001; c++) begin
            step();
            if (inc || dec) strobes++;
        end
        keys(0, 1, 0);
        for (int c = 0; c < 700; c++) begin
            step();
            if (inc || dec) strobes++;
        end
        check_int("no_strobe_after_reset", strobes, 0);
        check("held_up_in_edit_s", {1'b0, 3'b001, 1'b0, 1'b0, 3'b111, 1'b1});
        keys(0, 0, 0);
        step();
        keys(0, 1, 0);
        step();
        check("fresh_press_after_reset", {1'b0, 3'b001, 1'b1, 1'b0, 3'b111, 1'b1});
        keys(0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
